// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: branch misprediction recovery sequencer.
// Issues a held redirect PC, drains the front end, and keeps branch stats.
module branch_redirect_ctrl #(
    parameter int WordSize    = 32,
    parameter int FlushCycles = 2,
    parameter int CntW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic                res_pred_taken,
    input  logic                res_act_taken,
    input  logic [WordSize-1:0] res_pred_target,
    input  logic [WordSize-1:0] res_act_target,
    input  logic [WordSize-1:0] res_fallthru,
    output logic                redir_valid,
    input  logic                redir_ready,
    output logic [WordSize-1:0] redir_pc,
    output logic                flush,
    output logic [CntW-1:0]     branch_cnt,
    output logic [CntW-1:0]     mispred_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        DRAIN
    } state_t;

    localparam logic [CntW-1:0] CntMax    = '1;
    localparam logic [3:0]      DrainLoad = 4'(FlushCycles - 1);

    state_t              state_q, state_d;
    logic [WordSize-1:0] redir_pc_q, redir_pc_d;
    logic [3:0]          drain_q, drain_d;
    logic                redir_valid_q, redir_valid_d;
    logic                flush_q, flush_d;
    logic [CntW-1:0]     branch_cnt_q, branch_cnt_d;
    logic [CntW-1:0]     mispred_cnt_q, mispred_cnt_d;
    logic                accept;
    logic                mispredict;

    assign res_ready   = (state_q == IDLE);
    assign accept      = res_valid && res_ready;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // Target compare only matters when the branch is actually taken.
    assign mispredict = (res_pred_taken != res_act_taken) ||
                        (res_act_taken &&
                         (res_pred_target != res_act_target));

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        redir_pc_d    = redir_pc_q;
        drain_d       = drain_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (branch_cnt_q != CntMax) begin
                        branch_cnt_d = branch_cnt_q + 1'b1;
                    end
                    if (mispredict) begin
                        if (mispred_cnt_q != CntMax) begin
                            mispred_cnt_d = mispred_cnt_q + 1'b1;
                        end
                        redir_pc_d = res_act_taken ? res_act_target
                                                   : res_fallthru;
                        state_d    = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    drain_d = DrainLoad;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        redir_valid_d = (state_d == REDIRECT);
        flush_d       = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            redir_pc_q    <= '0;
            drain_q       <= '0;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redir_pc_q    <= redir_pc_d;
            drain_q       <= drain_d;
            redir_valid_q <= redir_valid_d;
            flush_q       <= flush_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: randomized bench with a behavioural model
// of the redirect/flush/counter rules plus pinned literal scenarios.
module tb_branch_redirect_ctrl;

    localparam int W    = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic          res_pred_taken = 1'b0;
    logic          res_act_taken = 1'b0;
    logic [W-1:0]  res_pred_target = '0;
    logic [W-1:0]  res_act_target = '0;
    logic [W-1:0]  res_fallthru = '0;
    logic          redir_valid;
    logic          redir_ready = 1'b0;
    logic [W-1:0]  redir_pc;
    logic          flush;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    branch_redirect_ctrl #(
        .WordSize   (W),
        .FlushCycles(FC),
        .CntW       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_pred_taken (res_pred_taken),
        .res_act_taken  (res_act_taken),
        .res_pred_target(res_pred_target),
        .res_act_target (res_act_target),
        .res_fallthru   (res_fallthru),
        .redir_valid    (redir_valid),
        .redir_ready    (redir_ready),
        .redir_pc       (redir_pc),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pending redirect flag, the number of flush
    // cycles still owed after the redirect handshake, and plain counts.
    bit          m_pend = 1'b0;
    logic [W-1:0] m_pc = '0;
    int          m_drain = 0;
    int          m_bc = 0;
    int          m_mc = 0;

    function automatic bit wrong_guess(bit pt, bit at,
                                       logic [W-1:0] ptg,
                                       logic [W-1:0] atg);
        if (pt != at) return 1'b1;
        if (at && ptg != atg) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend  = 1'b0;
            m_pc    = '0;
            m_drain = 0;
            m_bc    = 0;
            m_mc    = 0;
        end else if (!m_pend && m_drain == 0) begin
            if (res_valid) begin
                if (m_bc < CMAX) m_bc = m_bc + 1;
                if (wrong_guess(res_pred_taken, res_act_taken,
                                res_pred_target, res_act_target)) begin
                    if (m_mc < CMAX) m_mc = m_mc + 1;
                    m_pend = 1'b1;
                    m_pc   = res_act_taken ? res_act_target : res_fallthru;
                end
            end
        end else if (m_pend) begin
            if (redir_ready) begin
                m_pend  = 1'b0;
                m_drain = FC;
            end
        end else begin
            m_drain = m_drain - 1;
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("res_ready", 32'(res_ready),
                  32'(!m_pend && m_drain == 0));
            check("redir_valid", 32'(redir_valid), 32'(m_pend));
            check("flush", 32'(flush), 32'(m_pend || m_drain > 0));
            check("redir_pc", redir_pc, m_pc);
            check("branch_cnt", 32'(branch_cnt), 32'(m_bc));
            check("mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_res();
        res_pred_taken  = 1'($urandom);
        res_act_taken   = 1'($urandom);
        res_pred_target = $urandom;
        res_act_target  = $urandom;
        res_fallthru    = $urandom;
    endtask

    task automatic wait_ready(string name);
        int k;
        k = 0;
        while (!res_ready && k < 50) begin
            step();
            k++;
        end
        check(name, 32'(res_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] pick_tgt();
        logic [W-1:0] t;
        case ($urandom_range(0, 3))
            0: t = 32'h200;
            1: t = 32'h300;
            2: t = 32'h1040;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    int k;
    int rises;
    int last_rise;
    int cyc;
    bit prev_rv;

    initial begin
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        check("rst_res_ready", 32'(res_ready), 32'd1);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redir_pc", redir_pc, 32'd0);
        check("rst_branch_cnt", 32'(branch_cnt), 32'd0);

        // Correct not-taken branch.
        rand_res();
        res_pred_taken = 1'b0;
        res_act_taken  = 1'b0;
        res_valid      = 1'b1;
        step();
        res_valid = 1'b0;
        check("nt_branch_cnt", 32'(branch_cnt), 32'd1);
        check("nt_mispred_cnt", 32'(mispred_cnt), 32'd0);
        check("nt_redir_valid", 32'(redir_valid), 32'd0);
        check("nt_res_ready", 32'(res_ready), 32'd1);

        // Direction mispredict, fetch ready immediately.
        rand_res();
        res_pred_taken = 1'b0;
        res_act_taken  = 1'b1;
        res_act_target = 32'h0000_1040;
        redir_ready    = 1'b1;
        res_valid      = 1'b1;
        step();
        res_valid = 1'b0;
        check("dir_redir_valid", 32'(redir_valid), 32'd1);
        check("dir_flush", 32'(flush), 32'd1);
        check("dir_redir_pc", redir_pc, 32'h1040);
        k = 1;
        while (!res_ready && k < 20) begin
            step();
            k++;
        end
        check("dir_ready_latency", k, 32'd4);
        check("dir_mispred_cnt", 32'(mispred_cnt), 32'd1);

        // Target mispredict with fetch stalled for 5 cycles.
        rand_res();
        res_pred_taken  = 1'b1;
        res_act_taken   = 1'b1;
        res_pred_target = 32'h200;
        res_act_target  = 32'h300;
        redir_ready     = 1'b0;
        res_valid       = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("tgt_hold_valid", 32'(redir_valid), 32'd1);
            check("tgt_hold_pc", redir_pc, 32'h300);
            check("tgt_hold_ready", 32'(res_ready), 32'd0);
            rand_res();
            step();
        end
        res_valid   = 1'b0;
        redir_ready = 1'b1;
        wait_ready("tgt_complete");
        check("tgt_branch_cnt", 32'(branch_cnt), 32'd3);
        check("tgt_mispred_cnt", 32'(mispred_cnt), 32'd2);

        // Predicted taken, actually not taken.
        rand_res();
        res_pred_taken = 1'b1;
        res_act_taken  = 1'b0;
        res_fallthru   = 32'h0000_0104;
        res_valid      = 1'b1;
        step();
        res_valid = 1'b0;
        check("ft_redir_pc", redir_pc, 32'h104);
        wait_ready("ft_complete");

        // Reset while draining.
        rand_res();
        res_pred_taken = 1'b0;
        res_act_taken  = 1'b1;
        res_valid      = 1'b1;
        step();
        res_valid = 1'b0;
        step();
        check("drain_flush", 32'(flush), 32'd1);
        check("drain_redir_valid", 32'(redir_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("drst_flush", 32'(flush), 32'd0);
        check("drst_res_ready", 32'(res_ready), 32'd1);
        check("drst_branch_cnt", 32'(branch_cnt), 32'd0);
        check("drst_mispred_cnt", 32'(mispred_cnt), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("drst_no_redir", 32'(redir_valid), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            res_valid       = ($urandom_range(0, 3) != 0);
            res_pred_taken  = 1'($urandom);
            res_act_taken   = ($urandom_range(0, 3) == 0) ?
                              ~res_pred_taken : res_pred_taken;
            res_pred_target = pick_tgt();
            res_act_target  = ($urandom_range(0, 1) == 0) ?
                              res_pred_target : pick_tgt();
            res_fallthru    = $urandom;
            redir_ready     = 1'($urandom);
            rst             = ($urandom_range(0, 63) == 0);
            step();
        end
        rst         = 1'b0;
        res_valid   = 1'b0;
        redir_ready = 1'b1;
        step();

        // Back-to-back mispredicts into saturation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        redir_ready = 1'b1;
        res_valid   = 1'b1;
        rises       = 0;
        last_rise   = 0;
        cyc         = 0;
        prev_rv     = 1'b0;
        while (rises < 20 && cyc < 300) begin
            rand_res();
            res_pred_taken = 1'b0;
            res_act_taken  = 1'b1;
            step();
            cyc++;
            if (redir_valid && !prev_rv) begin
                if (rises > 0) begin
                    check("b2b_spacing", cyc - last_rise, 32'd4);
                end
                last_rise = cyc;
                rises++;
            end
            prev_rv = redir_valid;
        end
        res_valid = 1'b0;
        check("b2b_redirects", rises, 32'd20);
        wait_ready("b2b_complete");
        check("sat_branch_cnt", 32'(branch_cnt), 32'd15);
        check("sat_mispred_cnt", 32'(mispred_cnt), 32'd15);

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
